// File: rtl/clk_ratio_ctrl.sv
// Rational M/N clock-enable scheduler running on clk_src.
// Produces a registered clk_out plus one-cycle rise/fall enables using an
// accumulator; ratio changes and stop/start happen only at toggle points.
module clk_ratio_ctrl #(
    parameter int unsigned W      = 16,
    parameter int unsigned M_INIT = 2,
    parameter int unsigned N_INIT = 75
) (
    input  logic         clk_src,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_m,
    input  logic [W-1:0] cfg_n,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         clk_out,
    output logic         ce_rise,
    output logic         ce_fall,
    output logic         running
);

    localparam int unsigned SW = W + 1;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_acc, w_acc_nxt;
    logic [W-1:0] r_m, w_m_nxt;
    logic [W-1:0] r_n, w_n_nxt;
    logic [W-1:0] r_pm, w_pm_nxt;
    logic [W-1:0] r_pn, w_pn_nxt;
    logic         r_clk, w_clk_nxt;
    logic         r_rise, w_rise_nxt;
    logic         r_fall, w_fall_nxt;
    logic         r_err, w_err_nxt;
    logic         r_cfg_ready;
    logic         r_running;

    logic [SW-1:0] w_sum;
    logic          w_hit;
    logic [W-1:0]  w_acc_step;
    logic          w_xfer;
    logic          w_legal;
    logic          w_load;
    logic          w_stop;

    // Accumulator step and config qualification
    assign w_sum      = SW'(r_acc) + (SW'(r_m) << 1);
    assign w_hit      = (w_sum >= SW'(r_n));
    assign w_acc_step = w_hit ? W'(w_sum - SW'(r_n)) : W'(w_sum);
    assign w_xfer     = cfg_valid & r_cfg_ready;
    assign w_legal    = (cfg_m != '0) && (cfg_n != '0) &&
                        ((SW'(cfg_m) << 1) <= SW'(cfg_n)) && !cfg_n[W-1];
    assign w_load     = w_xfer & w_legal;

    // Next-state, accumulator, ratio and output-pulse decisions
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_m_nxt     = r_m;
        w_n_nxt     = r_n;
        w_pm_nxt    = r_pm;
        w_pn_nxt    = r_pn;
        w_clk_nxt   = r_clk;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_err_nxt   = w_xfer & ~w_legal;
        w_stop      = 1'b0;
        case (r_state)
            ST_STOP: begin
                w_acc_nxt = '0;
                w_clk_nxt = 1'b0;
                if (w_load) begin
                    w_m_nxt = cfg_m;
                    w_n_nxt = cfg_n;
                end
                if (en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_PEND: begin
                if (!en && !r_clk) begin
                    // Already low: stop without touching clk_out
                    w_stop = 1'b1;
                end else begin
                    w_acc_nxt = w_acc_step;
                    if (w_hit) begin
                        w_clk_nxt  = ~r_clk;
                        w_rise_nxt = ~r_clk;
                        w_fall_nxt = r_clk;
                    end
                    if (w_hit && r_clk && !en) begin
                        w_stop = 1'b1;
                    end else if (r_state == ST_PEND && w_hit && !r_clk) begin
                        // New ratio takes over on a rising edge with a clean accumulator
                        w_acc_nxt   = '0;
                        w_m_nxt     = r_pm;
                        w_n_nxt     = r_pn;
                        w_state_nxt = ST_RUN;
                    end else if (r_state == ST_RUN && w_load) begin
                        w_pm_nxt    = cfg_m;
                        w_pn_nxt    = cfg_n;
                        w_state_nxt = ST_PEND;
                    end
                end
                if (w_stop) begin
                    w_state_nxt = ST_STOP;
                    w_acc_nxt   = '0;
                    if (r_state == ST_PEND) begin
                        w_m_nxt = r_pm;
                        w_n_nxt = r_pn;
                    end else if (w_load) begin
                        w_m_nxt = cfg_m;
                        w_n_nxt = cfg_n;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_src or posedge rst) begin
        if (rst) begin
            r_state     <= ST_STOP;
            r_acc       <= '0;
            r_m         <= W'(M_INIT);
            r_n         <= W'(N_INIT);
            r_pm        <= '0;
            r_pn        <= '0;
            r_clk       <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_err       <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_m         <= w_m_nxt;
            r_n         <= w_n_nxt;
            r_pm        <= w_pm_nxt;
            r_pn        <= w_pn_nxt;
            r_clk       <= w_clk_nxt;
            r_rise      <= w_rise_nxt;
            r_fall      <= w_fall_nxt;
            r_err       <= w_err_nxt;
            r_cfg_ready <= (w_state_nxt != ST_PEND);
            r_running   <= (w_state_nxt != ST_STOP);
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_err;
    assign clk_out   = r_clk;
    assign ce_rise   = r_rise;
    assign ce_fall   = r_fall;
    assign running   = r_running;

endmodule

// File: doc/clk_ratio_ctrl.md
Name: clk_ratio_ctrl

Overview:
- Runtime-programmable, glitch-free clock-enable scheduler running on the fast source clock.
- Generates an output clock and single-cycle rise/fall enables at an exact rational ratio M/N of clk_src, using an accumulator rather than an integer divide.
- Sits between the host/config logic and the VDP/PSG timing consumers.
- Reconfiguration and stop/start are sequenced so clk_out never produces a runt phase.

Parameters:
W, 16, accumulator/ratio width; N must be < 2^(W-1)
M_INIT, 2, numerator loaded at reset (output = clk_src*M/N)
N_INIT, 75, denominator loaded at reset (135 MHz * 2/75 = 3.6 MHz)

Ports:
clk_src  in  1  source clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  run request; level-sensitive
cfg_valid  in  1  new ratio offered
cfg_m  in  W  numerator
cfg_n  in  W  denominator
cfg_ready  out  1  high when a config can be accepted
cfg_err  out  1  one-cycle pulse: offered config rejected
clk_out  out  1  generated clock, registered
ce_rise  out  1  one-cycle pulse, same cycle clk_out becomes 1
ce_fall  out  1  one-cycle pulse, same cycle clk_out becomes 0
running  out  1  high in RUN or PEND

Behaviour:
- Reset values: state=STOP; acc=0; m=M_INIT; n=N_INIT; clk_out=0; ce_rise=ce_fall=0; cfg_err=0; running=0; cfg_ready=1.
- Step rule in RUN/PEND, evaluated each cycle:
  - s = acc + 2*m, computed W+1 bits wide.
  - If s >= n: toggle clk_out, acc <= s - n, pulse ce_rise or ce_fall.
  - Else: acc <= s.
- Average output period is exactly n/m source cycles. Half-periods differ by at most 1 cycle.
- Config legality: cfg_m != 0, cfg_n != 0, 2*cfg_m <= cfg_n, cfg_n < 2^(W-1).
  - Illegal config: handshake completes (cfg_ready was 1), cfg_err pulses next cycle, active m/n unchanged.
- Handshake: transfer occurs when cfg_valid & cfg_ready. cfg_valid with cfg_ready=0 is ignored; the offer must be held.
- State STOP:
  - clk_out=0, acc=0, cfg_ready=1.
  - Legal config loads m/n next cycle.
  - en=1 -> RUN next cycle with acc=0. The first rising toggle occurs on the ceil(n/(2m))-th RUN cycle.
- State RUN:
  - cfg_ready=1.
  - Legal config: captured into pending regs -> PEND.
  - en=0: keep stepping until the next falling toggle. On that toggle, acc<=0 and state -> STOP.
  - If en=0 while clk_out=0: stays stopped, i.e. goes to STOP immediately with no pulse.
- State PEND:
  - cfg_ready=0; stepping continues with the old m/n.
  - On the next rising toggle: clk_out<=1, ce_rise=1, acc<=0, m/n<=pending, state -> RUN. The first period on the new ratio starts clean.
  - If en=0: run to the next falling toggle, load pending into m/n, state -> STOP.
- Simultaneous events:
  - cfg transfer and toggle in the same RUN cycle: the toggle uses the old m/n; the config is applied at the following rising toggle.
  - en deasserted and reasserted before the falling toggle: the stop is cancelled, no gap.
- clk_out must only change at computed toggle points: no runt, no double toggle in one cycle.
- Asynchronous reset mid-operation returns all outputs to reset values immediately. Pending config is discarded.
- Never use clk_out as a clock inside this block. Consumers use ce_rise/ce_fall with clk_src.

Test Plan:
- Reset, en=1, M=2, N=75:
  - First ce_rise after 19 RUN cycles.
  - Rise-to-rise intervals alternate 37/38, and 1000 periods span exactly 37500 cycles.
- Program M=1, N=6 while running -> cfg_ready low until the next rise; afterwards the period is exactly 6 cycles, 3 high / 3 low, and the stretched/short phase is never < 3 cycles.
- Offer cfg_m=40, cfg_n=75 (2m>n), then cfg_m=0 -> two cfg_err pulses, ratio unchanged, period still 37/38.
- en=0 while clk_out=1 -> clk_out stays 1 until the scheduled fall, then STOP with running=0. Re-enabling 5 cycles later restarts with acc=0.
- Assert rst mid-PEND -> clk_out=0, cfg_ready=1 immediately; after release the ratio is back to 2/75.
- Boundary M=1, N=2 (2m=n) -> clk_out toggles every cycle, ce_rise/ce_fall alternate, and no cycle has both pulses.
